// File: rtl/bus_copy_pkg.sv
// Shared types and constants for the block-copy bus initiator.
package bus_copy_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        READ     = 3'd1,
        WR_SETUP = 3'd2,
        WRITE    = 3'd3,
        RD_SETUP = 3'd4,
        FINISH   = 3'd5
    } state_t;

    localparam int DEFAULT_ADDR_STEP = 4;

    // Byte-address advance; wraps modulo 2^32 by construction.
    function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [31:0] step);
        return addr + step;
    endfunction

endpackage

// File: rtl/bus_copy_initiator.sv
// Copies N words from a source to a destination range over a single-outstanding
// request/ready bus: one read, then one write per word.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for i_start; no bus activity
// READ     | read request to src held until i_ready
// WR_SETUP | request low for one cycle; write data presented
// WRITE    | write request to dst held until i_ready
// RD_SETUP | request low for one cycle before the next read
// FINISH   | o_done pulse, then back to IDLE
module bus_copy_initiator
    import bus_copy_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int ADDR_STEP   = DEFAULT_ADDR_STEP,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   i_clock,
    input  logic                   i_reset_n,
    input  logic                   i_start,
    input  logic [31:0]            i_src,
    input  logic [31:0]            i_dst,
    input  logic [COUNT_WIDTH-1:0] i_count,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_error,
    output logic                   o_request,
    output logic                   o_rw,
    output logic [31:0]            o_address,
    output logic [WIDTH-1:0]       o_wdata,
    input  logic [WIDTH-1:0]       i_rdata,
    input  logic                   i_ready,
    input  logic                   i_valid
);

    localparam logic [31:0]            STEP = 32'(ADDR_STEP);
    localparam logic [COUNT_WIDTH-1:0] ONE  = COUNT_WIDTH'(1);

    state_t                 state;
    logic [31:0]            src_q;
    logic [31:0]            dst_q;
    logic [COUNT_WIDTH-1:0] remaining_q;

    // All outputs are registered; each transition loads the values the next state presents.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state       <= IDLE;
            src_q       <= '0;
            dst_q       <= '0;
            remaining_q <= '0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_error     <= 1'b0;
            o_request   <= 1'b0;
            o_rw        <= 1'b0;
            o_address   <= '0;
            o_wdata     <= '0;
        end else begin
            o_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        o_error <= 1'b0;
                        o_busy  <= 1'b1;
                        if (i_count != '0) begin
                            src_q       <= i_src;
                            dst_q       <= i_dst;
                            remaining_q <= i_count;
                            o_request   <= 1'b1;
                            o_rw        <= 1'b0;
                            o_address   <= i_src;
                            state       <= READ;
                        end else begin
                            o_done <= 1'b1;
                            state  <= FINISH;
                        end
                    end
                end

                READ: begin
                    if (i_ready) begin
                        o_request <= 1'b0;
                        if (i_valid) begin
                            o_wdata <= i_rdata;
                            state   <= WR_SETUP;
                        end else begin
                            o_error <= 1'b1;
                            o_done  <= 1'b1;
                            state   <= FINISH;
                        end
                    end
                end

                WR_SETUP: begin
                    o_request <= 1'b1;
                    o_rw      <= 1'b1;
                    o_address <= dst_q;
                    state     <= WRITE;
                end

                WRITE: begin
                    if (i_ready) begin
                        o_request <= 1'b0;
                        if (!i_valid) begin
                            o_error <= 1'b1;
                            o_done  <= 1'b1;
                            state   <= FINISH;
                        end else begin
                            src_q       <= next_addr(src_q, STEP);
                            dst_q       <= next_addr(dst_q, STEP);
                            remaining_q <= remaining_q - ONE;
                            if (remaining_q == ONE) begin
                                o_done <= 1'b1;
                                state  <= FINISH;
                            end else begin
                                state <= RD_SETUP;
                            end
                        end
                    end
                end

                RD_SETUP: begin
                    o_request <= 1'b1;
                    o_rw      <= 1'b0;
                    o_address <= src_q;
                    state     <= READ;
                end

                FINISH: begin
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end

                default: begin
                    o_busy    <= 1'b0;
                    o_request <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
